// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and load/store,
// one transaction at a time, with registered read data and one-cycle completion pulses.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_func3,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state,
    output logic [CNT_W-1:0]  dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [2:0]         mem_func3_q, mem_func3_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               if_valid_q, if_valid_d;
    logic               d_valid_q, d_valid_d;

    // Handshake: a requester holds req until its valid pulse; the memory holds mem_req and all
    // mem_* stable until it answers with mem_ready. A req seen alongside its own valid is stale.
    logic if_want, d_want, starved, grant_d, grant_i;
    assign if_want = if_req & ~if_valid_q;
    assign d_want  = d_req & ~d_valid_q;
    assign starved = (cnt_q == CNT_W'(STARVE_MAX));
    assign grant_d = d_want & ~(if_want & starved);
    assign grant_i = if_want & ~grant_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_func3_d = mem_func3_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_func3_d = d_func3;
                    if (if_req && !starved) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (grant_i) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 32'd0;
                    mem_func3_d = 3'b010;
                    cnt_d       = '0;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_func3_q <= 3'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_func3_q <= mem_func3_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_func3      = mem_func3_q;
    assign if_rdata       = if_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign if_valid       = if_valid_q;
    assign d_valid        = d_valid_q;
    assign if_stall       = if_req & ~if_valid_q;
    assign d_stall        = d_req & ~d_valid_q;
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = cnt_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the instruction-fetch requester and the load/store requester of the pipelined RISC-V core.
- Arbitrates between the two requesters, sequences one memory transaction at a time over a req/ready handshake, and returns registered read data with a one-cycle valid pulse.
- Drives per-requester stall signals that freeze the pipeline registers while an access is outstanding.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is waiting; when reached, the next grant goes to fetch.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle pulse: fetch complete
- if_stall  out  1  = if_req & ~if_valid
- d_req  in  1  load/store request; held high until d_valid
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  32  store data
- d_func3  in  3  access size/sign, passed through unchanged
- d_rdata  out  32  load data
- d_valid  out  1  one-cycle pulse: load/store complete
- d_stall  out  1  = d_req & ~d_valid
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_func3  out  3  to memory; 3'b010 for fetches
- mem_rdata  in  32  memory read data, valid when mem_ready
- mem_ready  in  1  memory completes the access in this cycle

Behaviour:
- Reset (rst = 0, asynchronous):
  - State = IDLE.
  - All outputs 0: mem_*, if_rdata, d_rdata, if_valid, d_valid.
  - Starvation counter = 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, arbitration. Evaluated only in IDLE:
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both requests -> BUSY_D, unless the counter == STARVE_MAX, in which case -> BUSY_I.
  - No request -> stay in IDLE.
- On the grant edge, register the address, we, wdata and func3 into the mem_* outputs and set mem_req = 1.
  - A fetch always drives mem_we = 0 and mem_func3 = 3'b010.
- BUSY_x:
  - mem_req and all mem_* outputs stay stable until a cycle with mem_ready = 1.
  - On that edge: mem_req <= 0, the matching valid <= 1 for exactly one cycle, and the next state is IDLE.
  - Loads and fetches register mem_rdata into d_rdata / if_rdata.
  - Stores leave d_rdata unchanged.
- Latency:
  - Request seen in IDLE at cycle N -> mem_req high from N+1.
  - mem_ready at cycle M (M >= N+1) -> valid and rdata at M+1, state IDLE at M+1.
  - Zero-wait memory: 2-cycle access. Back-to-back accesses take 3 cycles each, with one IDLE bubble.
- Valid-cycle rule: in a cycle where a valid is high, the arbiter is in IDLE and already arbitrates.
  - The completing requester's req is still high in that cycle, so the arbiter ignores the req of the requester whose valid is currently high.
  - This prevents a duplicate access.
- Starvation counter:
  - +1 on each data grant made while if_req = 1; saturates at STARVE_MAX.
  - Cleared on any fetch grant.
  - Unchanged otherwise.
- Request dropped while in BUSY_x: the transaction still completes and valid still pulses. There is no abort.
- if_rdata and d_rdata hold their value until the next completing load or fetch.
- mem_ready while in IDLE is ignored.
- Reset mid-transaction: mem_req drops immediately and no valid is produced.
- Stalls are combinational from req and valid only. There are no paths from mem_* inputs to stalls.

Test Plan:
- Single fetch, zero-wait:
  - Stimulus: if_req = 1, if_addr = 0x0000_0010, memory returns 0x0050_0093 with mem_ready in the first cycle of mem_req.
  - Required: mem_addr = 0x10, mem_we = 0, mem_func3 = 010; if_valid one cycle with if_rdata = 0x0050_0093; if_stall high for 2 cycles.
- Store with wait states:
  - Stimulus: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, d_func3 = 010, mem_ready after 3 cycles.
  - Required: mem_* stable for 3 cycles; d_valid one pulse; d_rdata unchanged.
- Simultaneous requests:
  - Stimulus: if_req and d_req both high in the same cycle.
  - Required: data is served first; fetch is granted on the IDLE cycle after d_valid; if_stall stays high throughout.
- Starvation, STARVE_MAX = 4:
  - Stimulus: if_req held high; d_req re-asserted continuously.
  - Required: 4 data grants, then 1 fetch grant, then the counter reads 0.
- Asynchronous reset mid-transaction:
  - Stimulus: rst = 0 in BUSY_D with no mem_ready.
  - Required: mem_req = 0 in the same cycle; no d_valid; after release, a new request is served normally.
- Dropped request:
  - Stimulus: d_req deasserted in BUSY_D.
  - Required: access completes and d_valid pulses once; no second access is issued.
